// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin arbiter sharing one ALU between EX stage (req0) and aux unit (req1)
// Optional build macro ALU_ARB_PERF_EN adds saturating handshake/conflict counters.
module alu_rr_arbiter #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_src,
    output logic [DATA_WIDTH-1:0]    rsp_result
`ifdef ALU_ARB_PERF_EN
    ,
    input  logic                     perf_clr,
    output logic [15:0]              perf_cnt0,
    output logic [15:0]              perf_cnt1,
    output logic [15:0]              perf_conflict
`endif
);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_LT  = OPCODE_LENGTH'(4'b1001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1110);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } slot_state_t;

    slot_state_t               r_state;
    slot_state_t               w_state_nxt;
    logic                      r_last_grant;
    logic                      r_rsp_src;
    logic [DATA_WIDTH-1:0]     r_rsp_result;
    logic                      w_accept_ok;
    logic                      w_gnt_valid;
    logic                      w_gnt_sel;
    logic                      w_hs;
    logic [OPCODE_LENGTH-1:0]  w_op;
    logic [DATA_WIDTH-1:0]     w_a;
    logic [DATA_WIDTH-1:0]     w_b;
    logic [4:0]                w_shamt;
    logic [DATA_WIDTH-1:0]     w_alu;

    // Grant selection and accept gating; readies are forced low while reset is held
    always_comb begin
        w_gnt_valid = req0_valid | req1_valid;
        w_gnt_sel   = (req0_valid & req1_valid) ? ~r_last_grant : req1_valid;
        w_accept_ok = ~reset & ((r_state == S_EMPTY) | rsp_ready);
        req0_ready  = w_accept_ok & w_gnt_valid & ~w_gnt_sel;
        req1_ready  = w_accept_ok & w_gnt_valid & w_gnt_sel;
        w_hs        = w_accept_ok & w_gnt_valid;
        w_op        = w_gnt_sel ? req1_op : req0_op;
        w_a         = w_gnt_sel ? req1_a  : req0_a;
        w_b         = w_gnt_sel ? req1_b  : req0_b;
    end

    // Shared ALU operating on the granted requester's operands
    always_comb begin
        w_shamt = w_b[4:0];
        w_alu   = '0;
        case (w_op)
            OP_AND: w_alu = w_a & w_b;
            OP_OR:  w_alu = w_a | w_b;
            OP_XOR: w_alu = w_a ^ w_b;
            OP_ADD: w_alu = w_a + w_b;
            OP_SUB: w_alu = w_a - w_b;
            OP_EQ:  w_alu = {{(DATA_WIDTH-1){1'b0}}, (w_a == w_b)};
            OP_LT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            OP_SLL: w_alu = w_a << w_shamt;
            OP_SRL: w_alu = w_a >> w_shamt;
            OP_SRA: w_alu = DATA_WIDTH'($signed(w_a) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // Slot next state: a simultaneous drain and accept keeps the slot full (reload)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_hs) w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready & ~w_hs) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Slot state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Response payload and round-robin pointer; pointer moves only on handshakes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_result <= '0;
            r_rsp_src    <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_hs) begin
            r_rsp_result <= w_alu;
            r_rsp_src    <= w_gnt_sel;
            r_last_grant <= w_gnt_sel;
        end
    end

    assign rsp_valid  = (r_state == S_FULL);
    assign rsp_src    = r_rsp_src;
    assign rsp_result = r_rsp_result;

`ifdef ALU_ARB_PERF_EN
    logic [15:0] r_perf_cnt0;
    logic [15:0] r_perf_cnt1;
    logic [15:0] r_perf_conflict;
    logic        w_conflict;

    assign w_conflict = req0_valid & req1_valid & w_accept_ok;

    // Saturating counters; clear wins over a same-cycle increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cnt0     <= '0;
            r_perf_cnt1     <= '0;
            r_perf_conflict <= '0;
        end else if (perf_clr) begin
            r_perf_cnt0     <= '0;
            r_perf_cnt1     <= '0;
            r_perf_conflict <= '0;
        end else begin
            if (req0_ready & req0_valid & (r_perf_cnt0 != 16'hFFFF))
                r_perf_cnt0 <= r_perf_cnt0 + 16'd1;
            if (req1_ready & req1_valid & (r_perf_cnt1 != 16'hFFFF))
                r_perf_cnt1 <= r_perf_cnt1 + 16'd1;
            if (w_conflict & (r_perf_conflict != 16'hFFFF))
                r_perf_conflict <= r_perf_conflict + 16'd1;
        end
    end

    assign perf_cnt0     = r_perf_cnt0;
    assign perf_cnt1     = r_perf_cnt1;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one combinational ALU instance between two requesters: requester 0 is the pipeline EX stage, requester 1 is the auxiliary unit (address/CSR helper).
- Round-robin arbitration with valid/ready handshakes.
- The ALU result goes into a single-entry registered response slot with backpressure.
- Sits between the EX-stage issue logic and the shared ALU; sustains one operation per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU operation code width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  OPCODE_LENGTH  requester 0 ALU operation
req0_a  input  DATA_WIDTH  requester 0 operand A (signed)
req0_b  input  DATA_WIDTH  requester 0 operand B (signed)
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_op  input  OPCODE_LENGTH  requester 1 ALU operation
req1_a  input  DATA_WIDTH  requester 1 operand A (signed)
req1_b  input  DATA_WIDTH  requester 1 operand B (signed)
rsp_valid  output  1  response slot holds a result
rsp_ready  input  1  consumer takes the result this cycle
rsp_src  output  1  requester that issued the held result (0/1)
rsp_result  output  DATA_WIDTH  registered ALU result

Behaviour:
- Reset: asynchronous and active-high; clears all state immediately.
  - Reset values: rsp_valid=0, rsp_src=0, rsp_result=0, slot state EMPTY, last_grant=1 (requester 0 wins first conflict).
  - req0_ready/req1_ready are 0 while reset is high.
  - Reset mid-operation discards any held result; no response is produced for it.
- ALU function (op -> result), all others -> 0:
  - 0000 AND; 0001 OR; 0010 XOR; 0100 ADD; 0101 SUB (wrap modulo 2^DATA_WIDTH).
  - 1000 EQ -> 1/0; 1001 signed LT -> 1/0.
  - 1100 SLL; 1101 SRL by b[4:0]; 1110 SRA by b[4:0].
- Slot FSM, two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on rsp_ready with no accept.
  - FULL -> FULL on rsp_ready with accept (reload), or on no rsp_ready (hold).
- accept_ok = (state==EMPTY) | rsp_ready. Combinational: accepting while FULL and draining is allowed, giving 1 op/cycle throughput.
- Grant (combinational):
  - Only reqN_valid -> N.
  - Both valid -> the requester != last_grant.
  - Neither valid -> no grant.
- reqN_ready = accept_ok & grant==N. Never both high.
- reqN_ready depends combinationally on valids and rsp_ready. Requesters must not make valid depend on ready.
- On handshake (reqN_valid & reqN_ready), at the next edge:
  - rsp_result <= ALU(reqN_op, reqN_a, reqN_b); rsp_src <= N.
  - last_grant <= N; rsp_valid <= 1.
- Latency: result visible exactly 1 cycle after the handshake.
- While rsp_valid & !rsp_ready: rsp_result and rsp_src hold stable; no new grant.
- Requester protocol: a valid request not yet accepted keeps op/a/b stable. Violations are the requester's fault and are not checked.
- last_grant changes only on a handshake; idle cycles do not advance the pointer.

Optional Feature:
ALU_ARB_PERF_EN
- Defined: adds outputs perf_cnt0, perf_cnt1, perf_conflict (16 bits each).
  - perf_cnt0/perf_cnt1 count handshakes per requester.
  - perf_conflict counts cycles with both valid and accept_ok.
  - All counters saturate at 16'hFFFF and reset to 0.
  - Input perf_clr (1 bit) synchronously zeroes all three and has priority over increments in the same cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset then req0 ADD a=5, b=-7, rsp_ready=1 -> req0_ready=1 in cycle 0; cycle 1 rsp_valid=1, rsp_src=0, rsp_result=-2.
- Both requesters continuously valid (req0 SUB 10,3; req1 SLL 1,4), rsp_ready=1 -> grants alternate 0,1,0,1 after reset; results 7,16,7,16 on consecutive cycles.
- req1 SRA a=32'h80000000, b=32'h00000024 -> result 32'hF8000000 (shift 4 via b[4:0]); SRL with same operands -> 32'h08000000.
- Backpressure: result held with rsp_ready=0 for 3 cycles while req0 valid -> req0_ready=0, rsp_result stable; rsp_ready=1 -> req0 accepted the same cycle, new result next cycle.
- Assert reset while rsp_valid=1 (LT -1 < 1 -> 1 pending) -> rsp_valid drops to 0 immediately; first conflict after release is granted to requester 0.
- ALU_ARB_PERF_EN: 3 conflicting cycles -> perf_conflict=3, perf_cnt0=2, perf_cnt1=1; perf_clr together with a handshake -> all counters 0.
